reg_bank_sequencer: RTL and testbench

Control-side driver for the 8x8 register bank. Accepts 16-bit register-transfer instructions over a valid/ready handshake and issues the bank's read/write enables, selectors and indirect-mode strobe. Reads operands back from the bank's rx/ry/bus outputs, computes ALU results, and writes them back. Also maintains zero/carry flags. Sits between the instruction fetch path and the register bank.

---
 rtl/reg_bank_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_reg_bank_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_sequencer.sv
// reg_bank_sequencer: takes 16-bit register-transfer instructions over a
// valid/ready handshake and drives the 8x8 register bank (selectors, read/write
// enables, indirect strobe). It computes ALU results from the bank's read
// ports, writes them back, and keeps the zero/carry flags.
//
// Every instruction takes exactly three cycles:
//   state | meaning
//   IDLE  | ready for an instruction, bank controls quiet
//   OPER  | selectors driven, operands read, result and flags registered
//   WRITE | result presented, write enable for opcodes 1-7, done/err pulse
module reg_bank_sequencer #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              rb_read_en,
  output logic              rb_write_en,
  output logic [SEL_W-1:0]  rb_rx_sel,
  output logic [SEL_W-1:0]  rb_ry_sel,
  output logic              rb_indirect_en,
  output logic [DATA_W-1:0] rb_in_data,
  input  logic [DATA_W-1:0] rb_bus_data,
  input  logic [DATA_W-1:0] rb_rx_data,
  input  logic [DATA_W-1:0] rb_ry_data,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPER  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_MOVI = 4'd2;
  localparam logic [3:0] OP_LDI  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;

  state_t             state_q, state_d;
  logic [15:0]        instr_q, instr_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_c_q, flag_c_d;

  logic [3:0]         op;
  logic [SEL_W-1:0]   rx_f;
  logic [SEL_W-1:0]   ry_f;
  logic [DATA_W-1:0]  imm_f;
  logic [DATA_W:0]    sum;
  logic [DATA_W:0]    diff;
  logic               op_illegal;
  logic               op_writes;

  // Field decode of the latched instruction; ry and imm overlap by design.
  always_comb begin
    op         = instr_q[15:12];
    rx_f       = instr_q[9 +: SEL_W];
    ry_f       = instr_q[6 +: SEL_W];
    imm_f      = instr_q[DATA_W-1:0];
    op_illegal = (op > OP_CMP);
    op_writes  = (op >= OP_MOV) && (op <= OP_OR);
  end

  // Operand arithmetic; the top bit is carry for the sum and borrow for the difference.
  always_comb begin
    sum  = {1'b0, rb_rx_data} + {1'b0, rb_ry_data};
    diff = {1'b0, rb_rx_data} - {1'b0, rb_ry_data};
  end

  // State, latched instruction, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Next-state logic, result/flag capture and bank control outputs.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    result_d       = result_q;
    flag_z_d       = flag_z_q;
    flag_c_d       = flag_c_q;
    instr_ready    = 1'b0;
    rb_read_en     = 1'b0;
    rb_write_en    = 1'b0;
    rb_rx_sel      = '0;
    rb_ry_sel      = '0;
    rb_indirect_en = 1'b0;
    done           = 1'b0;
    err            = 1'b0;

    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = OPER;
        end
      end

      OPER: begin
        rb_rx_sel      = rx_f;
        rb_ry_sel      = ry_f;
        rb_read_en     = (op == OP_MOV) || (op == OP_LDI);
        rb_indirect_en = (op == OP_LDI);
        case (op)
          OP_MOV, OP_LDI: result_d = rb_bus_data;
          OP_MOVI:        result_d = imm_f;
          OP_ADD: begin
            result_d = sum[DATA_W-1:0];
            flag_z_d = (sum[DATA_W-1:0] == '0);
            flag_c_d = sum[DATA_W];
          end
          OP_SUB: begin
            result_d = diff[DATA_W-1:0];
            flag_z_d = (diff[DATA_W-1:0] == '0);
            flag_c_d = diff[DATA_W];
          end
          OP_AND: begin
            result_d = rb_rx_data & rb_ry_data;
            flag_z_d = ((rb_rx_data & rb_ry_data) == '0);
            flag_c_d = 1'b0;
          end
          OP_OR: begin
            result_d = rb_rx_data | rb_ry_data;
            flag_z_d = ((rb_rx_data | rb_ry_data) == '0);
            flag_c_d = 1'b0;
          end
          OP_CMP: begin
            // Flags only; the result register keeps the last written value.
            flag_z_d = (diff[DATA_W-1:0] == '0);
            flag_c_d = diff[DATA_W];
          end
          default: ;  // NOP and illegal opcodes leave result and flags alone
        endcase
        state_d = WRITE;
      end

      WRITE: begin
        rb_rx_sel   = rx_f;
        rb_ry_sel   = ry_f;
        rb_write_en = op_writes;
        done        = 1'b1;
        err         = op_illegal;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Write data always shows the last result so the bus is stable outside WRITE.
  always_comb begin
    rb_in_data = result_q;
    flag_z     = flag_z_q;
    flag_c     = flag_c_q;
  end

  // op NOP is decoded implicitly through the default arms above.
  logic unused_nop;
  always_comb unused_nop = (op == OP_NOP);

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: a behavioural 8x8 register bank closes the
// loop, directed instructions push expected retire records into a queue, and
// a monitor checks each done pulse against the head of that queue.
module tb_reg_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        rb_read_en;
  logic        rb_write_en;
  logic [2:0]  rb_rx_sel;
  logic [2:0]  rb_ry_sel;
  logic        rb_indirect_en;
  logic [7:0]  rb_in_data;
  logic [7:0]  rb_bus_data;
  logic [7:0]  rb_rx_data;
  logic [7:0]  rb_ry_data;
  logic        done;
  logic        err;
  logic        flag_z;
  logic        flag_c;

  always #5 clk = ~clk;

  reg_bank_sequencer #(.DATA_W(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .rb_read_en(rb_read_en), .rb_write_en(rb_write_en),
    .rb_rx_sel(rb_rx_sel), .rb_ry_sel(rb_ry_sel),
    .rb_indirect_en(rb_indirect_en), .rb_in_data(rb_in_data),
    .rb_bus_data(rb_bus_data), .rb_rx_data(rb_rx_data), .rb_ry_data(rb_ry_data),
    .done(done), .err(err), .flag_z(flag_z), .flag_c(flag_c)
  );

  // Register bank model: async read ports, write at the clock edge.
  logic [7:0] bank [8] = '{default: 8'h00};
  assign rb_rx_data  = bank[rb_rx_sel];
  assign rb_ry_data  = bank[rb_ry_sel];
  assign rb_bus_data = !rb_read_en    ? 8'h00 :
                       rb_indirect_en ? bank[bank[rb_ry_sel][2:0]] :
                                        bank[rb_ry_sel];
  always @(posedge clk) if (rb_write_en) bank[rb_rx_sel] <= rb_in_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       err;
    logic       we;
    logic [2:0] sel;
    logic [7:0] data;
    logic       z;
    logic       c;
  } exp_t;

  exp_t q[$];
  int   done_cyc[$];
  exp_t mon_e;

  function automatic exp_t mk(input string n, input logic er, input logic we,
                              input logic [2:0] s, input logic [7:0] d,
                              input logic z, input logic c);
    exp_t e;
    e.name = n; e.err = er; e.we = we; e.sel = s; e.data = d; e.z = z; e.c = c;
    return e;
  endfunction

  // Monitor: every done pulse retires the oldest expected record.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cyc.push_back(cyc);
        if (q.size() == 0) begin
          chk("unexpected_done", {15'd0, done}, 16'd0);
        end else begin
          mon_e = q.pop_front();
          chk({mon_e.name, "_err"}, {15'd0, err}, {15'd0, mon_e.err});
          chk({mon_e.name, "_we"}, {15'd0, rb_write_en}, {15'd0, mon_e.we});
          if (mon_e.we) begin
            chk({mon_e.name, "_sel"}, {13'd0, rb_rx_sel}, {13'd0, mon_e.sel});
            chk({mon_e.name, "_data"}, {8'd0, rb_in_data}, {8'd0, mon_e.data});
          end
          chk({mon_e.name, "_z"}, {15'd0, flag_z}, {15'd0, mon_e.z});
          chk({mon_e.name, "_c"}, {15'd0, flag_c}, {15'd0, mon_e.c});
        end
      end else begin
        chk("we_outside_write", {15'd0, rb_write_en}, 16'd0);
        chk("err_without_done", {15'd0, err}, 16'd0);
      end
    end
  end

  // Present one instruction at a negedge once ready, complete the handshake.
  task automatic issue(input logic [15:0] w, input exp_t e, input bit push,
                       input bit hold, output int hs_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", {15'd0, instr_ready}, 16'd1);
    hs_cyc = cyc;
    instr = w;
    instr_valid = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_retire();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("retire_timeout", 16'(q.size()), 16'd0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] w, input exp_t e);
    int hc;
    issue(w, e, 1'b1, 1'b0, hc);
    wait_retire();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hc;
    int base;
    logic [15:0] b2b_w [3];
    exp_t        b2b_e [3];

    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_ready", {15'd0, instr_ready}, 16'd1);
    chk("rst_outs", {7'd0, rb_read_en, rb_write_en, rb_indirect_en, done, err,
                     rb_rx_sel, rb_ry_sel}, 16'd0);
    chk("rst_flags", {14'd0, flag_z, flag_c}, 16'd0);
    chk("rst_in_data", {8'd0, rb_in_data}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MOVI r2,0x5A with ready timing
    issue(16'h245A, mk("movi_r2", 0, 1, 3'd2, 8'h5A, 0, 0), 1'b1, 1'b0, hc);
    chk("ready_oper", {15'd0, instr_ready}, 16'd0);
    @(posedge clk); #1;
    chk("ready_write", {15'd0, instr_ready}, 16'd0);
    @(posedge clk); #1;
    chk("ready_back", {15'd0, instr_ready}, 16'd1);
    wait_retire();
    chk("r2_5a", {8'd0, bank[2]}, 16'h005A);

    // ADD with carry out, SUB to zero
    run(16'h22F0, mk("movi_r1", 0, 1, 3'd1, 8'hF0, 0, 0));
    run(16'h2420, mk("movi_r2b", 0, 1, 3'd2, 8'h20, 0, 0));
    run(16'h4280, mk("add_r1r2", 0, 1, 3'd1, 8'h10, 0, 1));
    chk("r1_10", {8'd0, bank[1]}, 16'h0010);
    run(16'h2607, mk("movi_r3", 0, 1, 3'd3, 8'h07, 0, 1));
    run(16'h56C0, mk("sub_r3r3", 0, 1, 3'd3, 8'h00, 1, 0));
    chk("r3_00", {8'd0, bank[3]}, 16'h0000);

    // LDI r5,r4 with r4=6, r6=0x99
    run(16'h2806, mk("movi_r4", 0, 1, 3'd4, 8'h06, 1, 0));
    run(16'h2C99, mk("movi_r6", 0, 1, 3'd6, 8'h99, 1, 0));
    issue(16'h3B00, mk("ldi_r5", 0, 1, 3'd5, 8'h99, 1, 0), 1'b1, 1'b0, hc);
    chk("ldi_oper_ctl", {14'd0, rb_read_en, rb_indirect_en}, 16'h0003);
    chk("ldi_oper_sel", {10'd0, rb_rx_sel, rb_ry_sel}, {10'd0, 3'd5, 3'd4});
    wait_retire();
    chk("r5_99", {8'd0, bank[5]}, 16'h0099);

    // CMP then an illegal opcode
    run(16'h2203, mk("movi_r1b", 0, 1, 3'd1, 8'h03, 1, 0));
    run(16'h2405, mk("movi_r2c", 0, 1, 3'd2, 8'h05, 1, 0));
    run(16'h8280, mk("cmp_r1r2", 0, 0, 3'd1, 8'h00, 0, 1));
    chk("cmp_nowrite", {8'd0, bank[1]}, 16'h0003);
    run(16'hC000, mk("illegal_c", 1, 0, 3'd0, 8'h00, 0, 1));
    chk("illegal_nowrite", {8'd0, bank[0]}, 16'h0000);

    // AND, OR, MOV, doubling ADD, NOP
    run(16'h6280, mk("and_r1r2", 0, 1, 3'd1, 8'h01, 0, 0));
    run(16'h7280, mk("or_r1r2", 0, 1, 3'd1, 8'h05, 0, 0));
    issue(16'h1F40, mk("mov_r7r5", 0, 1, 3'd7, 8'h99, 0, 0), 1'b1, 1'b0, hc);
    chk("mov_oper_ctl", {14'd0, rb_read_en, rb_indirect_en}, 16'h0002);
    wait_retire();
    chk("r7_99", {8'd0, bank[7]}, 16'h0099);
    run(16'h4240, mk("add_r1r1", 0, 1, 3'd1, 8'h0A, 0, 0));
    chk("r1_0a", {8'd0, bank[1]}, 16'h000A);
    run(16'h0000, mk("nop", 0, 0, 3'd0, 8'h00, 0, 0));

    // Back-to-back with instr_valid held high
    b2b_w[0] = 16'h2011; b2b_e[0] = mk("b2b_movi", 0, 1, 3'd0, 8'h11, 0, 0);
    b2b_w[1] = 16'h4000; b2b_e[1] = mk("b2b_add",  0, 1, 3'd0, 8'h22, 0, 0);
    b2b_w[2] = 16'h5080; b2b_e[2] = mk("b2b_sub",  0, 1, 3'd0, 8'h1D, 0, 0);
    done_cyc.delete();
    base = 0;
    for (int i = 0; i < 3; i++) begin
      issue(b2b_w[i], b2b_e[i], 1'b1, 1'b1, hc);
      if (i == 0) base = hc;
    end
    instr_valid = 1'b0;
    wait_retire();
    chk("b2b_count", 16'(done_cyc.size()), 16'd3);
    for (int i = 0; i < 3; i++)
      if (i < done_cyc.size())
        chk($sformatf("b2b_done_cyc%0d", i), 16'(done_cyc[i] - base), 16'(3 * i + 2));
    chk("r0_1d", {8'd0, bank[0]}, 16'h001D);

    // Reset during OPER of MOVI r7,0xFF after flags are set
    run(16'h8440, mk("cmp_r2r1", 0, 0, 3'd2, 8'h00, 0, 1));
    issue(16'h2EFF, mk("aborted", 0, 0, 3'd0, 8'h00, 0, 0), 1'b0, 1'b0, hc);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {15'd0, instr_ready}, 16'd1);
    chk("abort_flags", {14'd0, flag_z, flag_c}, 16'd0);
    chk("abort_ctl", {14'd0, rb_write_en, done}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_r7", {8'd0, bank[7]}, 16'h0099);
    run(16'h2E42, mk("movi_r7", 0, 1, 3'd7, 8'h42, 0, 0));
    chk("r7_42", {8'd0, bank[7]}, 16'h0042);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
